// File: rtl/cache_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
// Shared widths, FSM state encoding and address-field helpers for the
// direct-mapped cache controller.
// Word address layout: {tag[TAG_W], index[INDEX_W], word[WORD_W]}.
// ---------------------------------------------------------------------------
package cache_pkg;

    localparam int DATA_W  = 32;
    localparam int INDEX_W = 5;
    localparam int TAG_W   = 6;
    localparam int WORD_W  = 3;
    localparam int ADDR_W  = TAG_W + INDEX_W + WORD_W;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        REFILL,
        WRITE_MEM,
        DONE
    } state_e;

    function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
        return TAG_W'(addr >> (INDEX_W + WORD_W));
    endfunction

    function automatic logic [INDEX_W-1:0] get_index(input logic [ADDR_W-1:0] addr);
        return INDEX_W'(addr >> WORD_W);
    endfunction

    function automatic logic [WORD_W-1:0] get_word(input logic [ADDR_W-1:0] addr);
        return WORD_W'(addr);
    endfunction

endpackage

// File: rtl/cache_controller_if.sv
// ---------------------------------------------------------------------------
// cache_controller_if
// Bundles the three buses around the cache controller:
//   cpu_*  : CPU word-request port (req strobe, ready completion pulse)
//   mem_*  : main-memory request/acknowledge port
//   st_*   : cache_storage array control and asynchronous read-back
// Modports:
//   master : the cache controller (drives storage and memory, answers CPU)
//   slave  : the environment (CPU, main memory, cache_storage)
// ---------------------------------------------------------------------------
interface cache_controller_if;
    import cache_pkg::*;

    logic                cpu_req;
    logic                cpu_we;
    logic [ADDR_W-1:0]   cpu_addr;
    logic [DATA_W-1:0]   cpu_wdata;
    logic [DATA_W-1:0]   cpu_rdata;
    logic                cpu_ready;

    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_rdata;
    logic                mem_ack;

    logic [INDEX_W-1:0]  st_index;
    logic [WORD_W-1:0]   st_word;
    logic                st_we_data;
    logic                st_we_tag;
    logic [TAG_W-1:0]    st_tag_in;
    logic [DATA_W-1:0]   st_data_in;
    logic [TAG_W-1:0]    st_tag_out;
    logic                st_valid_out;
    logic [DATA_W-1:0]   st_data_out;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ready,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack,
        output st_index, st_word, st_we_data, st_we_tag, st_tag_in, st_data_in,
        input  st_tag_out, st_valid_out, st_data_out
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack,
        input  st_index, st_word, st_we_data, st_we_tag, st_tag_in, st_data_in,
        output st_tag_out, st_valid_out, st_data_out
    );

endinterface

// File: rtl/cache_stats.sv
// ---------------------------------------------------------------------------
// cache_stats
// Saturating 16-bit hit/miss counter pair. Only instantiated when the
// controller is built with CACHE_STATS_EN.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   hit_inc_i     : one-cycle pulse per CPU request resolved as a hit
//   miss_inc_i    : one-cycle pulse per CPU request resolved as a miss
//   hit_count_o   : hits seen since reset, sticks at 16'hFFFF
//   miss_count_o  : misses seen since reset, sticks at 16'hFFFF
// ---------------------------------------------------------------------------
module cache_stats (
    input  logic        clk,
    input  logic        rst,
    input  logic        hit_inc_i,
    input  logic        miss_inc_i,
    output logic [15:0] hit_count_o,
    output logic [15:0] miss_count_o
);

    logic [15:0] hit_q, hit_d;
    logic [15:0] miss_q, miss_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            hit_q  <= hit_d;
            miss_q <= miss_d;
        end
    end

    always_comb begin
        hit_d  = hit_q;
        miss_d = miss_q;
        if (hit_inc_i && (hit_q != 16'hFFFF)) begin
            hit_d = hit_q + 16'd1;
        end
        if (miss_inc_i && (miss_q != 16'hFFFF)) begin
            miss_d = miss_q + 16'd1;
        end
    end

    assign hit_count_o  = hit_q;
    assign miss_count_o = miss_q;

endmodule

// File: rtl/cache_controller.sv
// ---------------------------------------------------------------------------
// cache_controller
// Direct-mapped, write-through, no-write-allocate cache controller. Serves
// one CPU word request at a time, refilling whole 8-word blocks from main
// memory on read misses and writing every store through to memory.
// Ports:
//   clk            : clock, rising edge
//   rst            : asynchronous active-high reset
//   bus (master)   : cpu_*, mem_* and st_* signal groups, see cache_controller_if
//   hit_count,
//   miss_count     : saturating request statistics (only with CACHE_STATS_EN)
// Build option:
//   CACHE_STATS_EN : adds the hit/miss statistics counters and their ports.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | waiting for cpu_req; latches we/addr/wdata on a request
// COMPARE   | tag check; read hit returns data, write hit updates the line
// REFILL    | fetching the 8 words of the block, one memory ack per word
// WRITE_MEM | writing the latched word through to main memory
// DONE      | request complete; cpu_ready pulses on the following cycle
// ---------------------------------------------------------------------------
module cache_controller
    import cache_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    cache_controller_if.master  bus
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]         hit_count,
    output logic [15:0]         miss_count
`endif
);

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                ready_q, ready_d;

    logic [TAG_W-1:0]    lat_tag;
    logic [INDEX_W-1:0]  lat_index;
    logic [WORD_W-1:0]   lat_word;
    logic                hit;
    logic                refill_last;

    assign lat_tag   = get_tag(addr_q);
    assign lat_index = get_index(addr_q);
    assign lat_word  = get_word(addr_q);

    assign hit         = bus.st_valid_out && (bus.st_tag_out == lat_tag);
    assign refill_last = (state_q == REFILL) && bus.mem_ack && (cnt_q == '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        // The completion pulse is registered off DONE so it lands one cycle
        // after the state that finishes the request.
        ready_d  = (state_q == DONE);

        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.st_word    = lat_word;
        bus.st_we_data = 1'b0;
        bus.st_we_tag  = 1'b0;
        bus.st_data_in = '0;

        case (state_q)
            IDLE: begin
                if (bus.cpu_req) begin
                    we_d    = bus.cpu_we;
                    addr_d  = bus.cpu_addr;
                    wdata_d = bus.cpu_wdata;
                    state_d = COMPARE;
                end
            end

            COMPARE: begin
                if (hit) begin
                    if (we_q) begin
                        bus.st_we_data = 1'b1;
                        bus.st_data_in = wdata_q;
                        state_d        = WRITE_MEM;
                    end else begin
                        rdata_d = bus.st_data_out;
                        state_d = DONE;
                    end
                end else if (we_q) begin
                    state_d = WRITE_MEM;
                end else begin
                    cnt_d   = '0;
                    state_d = REFILL;
                end
            end

            REFILL: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = {lat_tag, lat_index, cnt_q};
                bus.st_word  = cnt_q;
                if (bus.mem_ack) begin
                    bus.st_we_data = 1'b1;
                    bus.st_data_in = bus.mem_rdata;
                    if (cnt_q == '1) begin
                        // Tag/valid flip only with the last word, so the line
                        // never looks valid while partially filled.
                        bus.st_we_tag = 1'b1;
                        state_d       = COMPARE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            WRITE_MEM: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = addr_q;
                bus.mem_wdata = wdata_q;
                if (bus.mem_ack) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.cpu_rdata = rdata_q;
    assign bus.cpu_ready = ready_q;
    assign bus.st_index  = lat_index;
    assign bus.st_tag_in = lat_tag;

`ifdef CACHE_STATS_EN
    // The COMPARE that follows a refill is a guaranteed hit for a request
    // already counted as a miss, so it is excluded from the statistics.
    logic post_refill_q;
    logic hit_inc;
    logic miss_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            post_refill_q <= 1'b0;
        end else if (refill_last) begin
            post_refill_q <= 1'b1;
        end else if (state_q == COMPARE) begin
            post_refill_q <= 1'b0;
        end
    end

    assign hit_inc  = (state_q == COMPARE) && !post_refill_q && hit;
    assign miss_inc = (state_q == COMPARE) && !post_refill_q && !hit;

    cache_stats u_stats (
        .clk          (clk),
        .rst          (rst),
        .hit_inc_i    (hit_inc),
        .miss_inc_i   (miss_inc),
        .hit_count_o  (hit_count),
        .miss_count_o (miss_count)
    );
`else
    logic unused_refill_last;
    assign unused_refill_last = refill_last;
`endif

endmodule

// File: tb/tb_cache_controller.sv
module tb_cache_controller;
    import cache_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cache_controller_if bus();

`ifdef CACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    cache_controller dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.master)
`ifdef CACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 clk = ~clk;

    int n_vec     = 0;
    int n_miscmp  = 0;

    logic [31:0] mem     [16384];
    logic [31:0] ref_mem [16384];

    logic [5:0]  s_tag  [32];
    logic [31:0] s_valid;
    logic [31:0] s_data [256];

    logic [5:0]  ref_tag [32];
    logic [31:0] ref_valid;
    logic [31:0] last_rdata;

    int mem_cycles_total = 0;
    bit busy = 1'b0;
    int wait_left = 0;

    typedef struct {
        bit          we;
        logic [13:0] addr;
        logic [31:0] data;
    } mem_exp_t;

    typedef struct {
        bit          we;
        logic [31:0] rdata;
        int          n_st;
        int          n_tag;
        int          lat_base;
    } txn_exp_t;

    mem_exp_t mq[$];
    txn_exp_t sb[$];

    task automatic check_val(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, obs, exp, $time);
        end
    endtask

    // cache_storage model: asynchronous read, synchronous write, shared reset
    assign bus.st_tag_out   = s_tag[bus.st_index];
    assign bus.st_valid_out = s_valid[bus.st_index];
    assign bus.st_data_out  = s_data[{bus.st_index, bus.st_word}];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s_valid <= '0;
        end else begin
            if (bus.st_we_data) s_data[{bus.st_index, bus.st_word}] <= bus.st_data_in;
            if (bus.st_we_tag) begin
                s_tag[bus.st_index]   <= bus.st_tag_in;
                s_valid[bus.st_index] <= 1'b1;
            end
        end
    end

    // main memory responder: 0..2 wait cycles, ack may land in the request cycle
    always @(posedge clk) begin
        #2;
        if (!bus.mem_req) begin
            bus.mem_ack = 1'b0;
            busy = 1'b0;
        end else begin
            mem_cycles_total++;
            if (!busy) begin
                busy = 1'b1;
                wait_left = int'($urandom_range(0, 2));
            end
            if (wait_left == 0) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = mem[bus.mem_addr];
                if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
                busy = 1'b0;
            end else begin
                bus.mem_ack = 1'b0;
                wait_left--;
            end
        end
    end

    task automatic do_abort();
        rst = 1'b1;
        #1;
        check_val("rst_cpu_ready", bus.cpu_ready, 0);
        check_val("rst_cpu_rdata", bus.cpu_rdata, 0);
        check_val("rst_mem_req", bus.mem_req, 0);
        check_val("rst_st_we_data", bus.st_we_data, 0);
        @(posedge clk);
        #1;
        check_val("rst_cyc_mem_req", bus.mem_req, 0);
        check_val("rst_cyc_mem_we", bus.mem_we, 0);
        check_val("rst_cyc_st_we_tag", bus.st_we_tag, 0);
        check_val("rst_cyc_cpu_ready", bus.cpu_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        ref_valid  = '0;
        last_rdata = '0;
        mq.delete();
        sb.delete();
    endtask

    task automatic cpu_access(input bit we, input logic [13:0] addr,
                              input logic [31:0] wd, input int abort_acks);
        logic [5:0]  tg;
        logic [4:0]  ix;
        logic [2:0]  wo;
        bit          hit;
        bit          rmiss;
        txn_exp_t    rec;
        txn_exp_t    got;
        mem_exp_t    e;
        int          lat;
        int          acks;
        int          n_st;
        int          n_tw;
        int          cyc0;
        bit          done;

        tg    = addr[13:8];
        ix    = addr[7:3];
        wo    = addr[2:0];
        hit   = ref_valid[ix] && (ref_tag[ix] == tg);
        rmiss = !we && !hit;

        mq.delete();
        rec.we       = we;
        rec.rdata    = we ? last_rdata : ref_mem[addr];
        rec.n_st     = we ? (hit ? 1 : 0) : (hit ? 0 : 8);
        rec.n_tag    = rmiss ? 1 : 0;
        rec.lat_base = rmiss ? 3 : 2;
        if (rmiss) begin
            for (int w = 0; w < 8; w++) begin
                e.we   = 1'b0;
                e.addr = {tg, ix, 3'(w)};
                e.data = '0;
                mq.push_back(e);
            end
            ref_tag[ix]   = tg;
            ref_valid[ix] = 1'b1;
        end
        if (we) begin
            e.we   = 1'b1;
            e.addr = addr;
            e.data = wd;
            mq.push_back(e);
            ref_mem[addr] = wd;
        end
        sb.push_back(rec);

        @(negedge clk);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wd;
        cyc0 = mem_cycles_total;
        @(posedge clk);

        lat = 0; acks = 0; n_st = 0; n_tw = 0; done = 1'b0;
        while (!done) begin
            @(negedge clk);
            bus.cpu_req = 1'b0;
            if (abort_acks > 0 && acks == abort_acks) begin
                do_abort();
                return;
            end
            if (bus.cpu_ready) begin
                done = 1'b1;
            end else begin
                if (bus.mem_req && bus.mem_ack) begin
                    if (mq.size() == 0) begin
                        check_val("mem_unexpected", 1, 0);
                    end else begin
                        e = mq.pop_front();
                        check_val("mem_addr", bus.mem_addr, e.addr);
                        check_val("mem_we", bus.mem_we, e.we);
                        if (e.we) begin
                            check_val("mem_wdata", bus.mem_wdata, e.data);
                        end else begin
                            check_val("refill_we", bus.st_we_data, 1);
                            check_val("refill_index", bus.st_index, ix);
                            check_val("refill_word", bus.st_word, e.addr[2:0]);
                            check_val("refill_data", bus.st_data_in, ref_mem[e.addr]);
                            check_val("refill_tag_we", bus.st_we_tag, (e.addr[2:0] == 3'd7));
                        end
                    end
                    acks++;
                end
                if (bus.st_we_data) n_st++;
                if (bus.st_we_tag) begin
                    n_tw++;
                    check_val("tag_in", bus.st_tag_in, tg);
                end
                if (bus.st_we_data && !bus.mem_req) begin
                    check_val("wr_hit_index", bus.st_index, ix);
                    check_val("wr_hit_word", bus.st_word, wo);
                    check_val("wr_hit_data", bus.st_data_in, wd);
                end
                if (lat >= 200) begin
                    check_val("ready_timeout", 0, 1);
                    mq.delete();
                    sb.delete();
                    return;
                end
                @(posedge clk);
                lat++;
            end
        end

        got = sb.pop_front();
        check_val(we ? "wr_rdata_hold" : "rd_data", bus.cpu_rdata, got.rdata);
        check_val("st_we_data_cnt", n_st, got.n_st);
        check_val("st_we_tag_cnt", n_tw, got.n_tag);
        check_val("latency", lat, got.lat_base + (mem_cycles_total - cyc0));
        check_val("mem_left", mq.size(), 0);
        if (!got.we) last_rdata = got.rdata;
        @(posedge clk);
        @(negedge clk);
        check_val("ready_pulse", bus.cpu_ready, 0);
    endtask

    initial begin
        logic [13:0] a;
        logic [5:0]  rt;
        logic [4:0]  ri;

        for (int i = 0; i < 16384; i++) begin
            a = 14'(i);
            mem[i]     = {a, ~a, 4'hA};
            ref_mem[i] = {a, ~a, 4'hA};
        end
        ref_valid  = '0;
        last_rdata = '0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_cpu_ready", bus.cpu_ready, 0);
        check_val("reset_cpu_rdata", bus.cpu_rdata, 0);
        check_val("reset_mem_req", bus.mem_req, 0);
        check_val("reset_mem_we", bus.mem_we, 0);
        check_val("reset_mem_addr", bus.mem_addr, 0);
        check_val("reset_mem_wdata", bus.mem_wdata, 0);
        check_val("reset_st_we_data", bus.st_we_data, 0);
        check_val("reset_st_we_tag", bus.st_we_tag, 0);
        rst = 1'b0;

        cpu_access(1'b0, 14'h0123, 32'h0, 0);          // cold miss, refill line 4
        cpu_access(1'b0, 14'h0125, 32'h0, 0);          // read hit
        cpu_access(1'b1, 14'h0125, 32'hDEADBEEF, 0);   // write hit
        cpu_access(1'b0, 14'h0125, 32'h0, 0);          // reads back DEADBEEF
        cpu_access(1'b1, 14'h3FC0, 32'hA5A50001, 0);   // write miss, no allocate
        cpu_access(1'b0, 14'h3FC0, 32'h0, 0);          // now refills line 24
        cpu_access(1'b0, 14'h0123, 32'h0, 0);          // hit
        cpu_access(1'b0, 14'h0923, 32'h0, 0);          // conflict on line 4
        cpu_access(1'b0, 14'h0123, 32'h0, 0);          // evicted, misses again
        cpu_access(1'b0, 14'h0456, 32'h0, 4);          // reset after 4 acks
        cpu_access(1'b0, 14'h0456, 32'h0, 0);          // full refill again
        cpu_access(1'b0, 14'h0123, 32'h0, 0);          // line 4 invalidated by reset

        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 2))
                0:       rt = 6'h01;
                1:       rt = 6'h09;
                default: rt = 6'h3F;
            endcase
            ri = ($urandom_range(0, 1) == 0) ? 5'd4 : 5'd5;
            a  = {rt, ri, 3'($urandom_range(0, 7))};
            if ($urandom_range(0, 9) < 3)
                cpu_access(1'b1, a, $urandom, 0);
            else
                cpu_access(1'b0, a, 32'h0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
